restoring_divider: RTL
======================

# restoring_divider

Sequential unsigned shift-subtract divider: the inverse companion of the shift-add multiplier datapath. It accepts a dividend/divisor pair on a start pulse and resolves one quotient bit per clock. It presents a registered quotient and remainder with a one-cycle done pulse. It includes its own control FSM and sits beside the multiplier in the arithmetic unit, sharing the same operand buses.

## Interface
- SIZE, 32, operand/quotient/remainder width in bits (≥2)
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin division; sampled only in IDLE
- Data_A  in  SIZE  dividend, sampled on the Start edge
- Data_B  in  SIZE  divisor, sampled on the Start edge
- Quotient  out  SIZE  registered quotient; reset 0
- Remainder  out  SIZE  registered remainder; reset 0
- Busy  out  1  high in LOAD-accepted/CALC states; reset 0
- Done  out  1  one-cycle pulse when results are valid; reset 0
- Div_By_Zero  out  1  registered; high with Done when divisor was 0; held until the next Start; reset 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE, Start=1 at edge:
  - load Dividend register = Data_A and Divisor register = Data_B;
  - clear partial remainder (SIZE+1 bits) and count = 0;
  - latch Div_By_Zero = (Data_B == 0);
  - go to CALC; Busy=1.
- IDLE, Start=0: hold; outputs keep their last results.
- CALC, each edge:
  - trial = {rem[SIZE-1:0], dividend MSB};
  - if trial ≥ divisor: rem = trial − divisor, quotient bit = 1; else rem = trial, quotient bit = 0;
  - shift dividend left, shifting the quotient bit into its LSB;
  - count += 1.
- On the edge where count reaches SIZE−1: commit Quotient/Remainder, go to DONE.
- DONE: Done=1 and Busy=0 for exactly one cycle; then IDLE.
- Start is ignored while Busy or in DONE; there is no queueing.
- Arithmetic:
  - unsigned only;
  - the comparison uses SIZE+1 bits, so no overflow occurs for divisor MSB=1.
- Divide by zero: the natural result is Quotient = all ones, Remainder = Data_A, with Div_By_Zero=1.

## Timing
- Start sampled at edge E0. Iterations occur at E1…E_SIZE. Done is high in the cycle after E_SIZE: latency is SIZE+1 cycles from the Start edge to Done; 33 for SIZE=32.
- Quotient/Remainder change only on the commit edge and remain stable until the next commit or Reset.
- Back-to-back: a Start asserted in the cycle Done is high is ignored. The earliest accepted Start is in the first IDLE cycle after Done.
- Reset at any edge, including mid-CALC:
  - state goes to IDLE;
  - all outputs and internal registers become 0;
  - a Start asserted in the same cycle is lost.

## Configuration
- DIV_BY_ZERO_SHORTCUT_EN defined:
  - Start with Data_B==0 goes from IDLE directly to DONE at E0;
  - Done appears in the cycle after E0;
  - Quotient = all ones and Remainder = Data_A are committed at E0.
- Undefined: a zero divisor runs all SIZE iterations and produces the same values through the normal algorithm, with Div_By_Zero=1.
- Result values are identical in both builds; only latency differs.

## Structure
- Shared package `arith_pkg`:
  - state enum (IDLE, CALC, DONE);
  - default width constant DIV_SIZE=32;
  - counter width function clog2.
- One natural sub-module: `div_step`, a combinational compare/subtract. Inputs: partial remainder, incoming dividend bit, divisor. Outputs: next remainder and quotient bit. It is instantiated once in the CALC datapath.
- Registers are plain synchronous-reset flops matching the existing register style.

## Test plan
- Data_A=100, Data_B=7, Start pulse → Done after 33 cycles; Quotient=14, Remainder=2, Div_By_Zero=0; Busy high 32 cycles.
- Data_A=0xFFFFFFFF, Data_B=0x80000000 → Quotient=1, Remainder=0x7FFFFFFF (MSB-set divisor boundary).
- Data_A=5, Data_B=9 → Quotient=0, Remainder=5.
- Data_A=1234, Data_B=0 → Quotient=0xFFFFFFFF, Remainder=1234, Div_By_Zero=1. Latency is 1 cycle with DIV_BY_ZERO_SHORTCUT_EN and 33 cycles without it.
- Start 100/7, then Start 50/5 pulsed at cycle 10 and again during the Done cycle → both ignored; result 14/2. Then Start 50/5 in IDLE → 10/0.
- Start 100/7, Reset asserted at cycle 15 → next cycle all outputs 0, state IDLE. A fresh Start 9/3 then yields 3/0 after 33 cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, default width and
// a constant-foldable ceil(log2) used to size iteration counters.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_SIZE = 32;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Operand/result bundle shared by the divider and whatever drives it
// (master = operand source, slave = divider).
import arith_pkg::*;

interface restoring_divider_if #(
  parameter int SIZE = DIV_SIZE
);
  logic            Start;
  logic [SIZE-1:0] Data_A;
  logic [SIZE-1:0] Data_B;
  logic [SIZE-1:0] Quotient;
  logic [SIZE-1:0] Remainder;
  logic            Busy;
  logic            Done;
  logic            Div_By_Zero;

  modport master (
    output Start, Data_A, Data_B,
    input  Quotient, Remainder, Busy, Done, Div_By_Zero
  );

  modport slave (
    input  Start, Data_A, Data_B,
    output Quotient, Remainder, Busy, Done, Div_By_Zero
  );
endinterface

// File: rtl/restoring_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference only when it does not go negative.
import arith_pkg::*;

module div_step #(
  parameter int SIZE = DIV_SIZE
) (
  input  logic [SIZE-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [SIZE-1:0] divisor_i,
  output logic [SIZE-1:0] rem_o,
  output logic            q_bit_o
);

  logic [SIZE:0] trial_s;

  // The trial carries the extra bit so a divisor with its MSB set compares
  // correctly; the kept remainder is always below the divisor, so the
  // subtraction can be done modulo 2**SIZE.
  always_comb begin
    trial_s = {rem_i, dividend_bit_i};
    if (trial_s >= {1'b0, divisor_i}) begin
      rem_o   = trial_s[SIZE-1:0] - divisor_i;
      q_bit_o = 1'b1;
    end else begin
      rem_o   = trial_s[SIZE-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_BY_ZERO_SHORTCUT_EN: a zero divisor skips CALC entirely.
import arith_pkg::*;

module restoring_divider #(
  parameter int SIZE = DIV_SIZE
) (
  input logic                Clock,
  input logic                Reset,
  restoring_divider_if.slave bus
);

  localparam int CNT_W = (clog2(SIZE) < 1) ? 1 : clog2(SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  div_state_e      state_q,     state_d;
  logic [SIZE-1:0] dividend_q,  dividend_d;
  logic [SIZE-1:0] divisor_q,   divisor_d;
  logic [SIZE-1:0] rem_q,       rem_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [SIZE-1:0] quotient_q,  quotient_d;
  logic [SIZE-1:0] remainder_q, remainder_d;
  logic            busy_q,      busy_d;
  logic            done_q,      done_d;
  logic            dbz_q,       dbz_d;

  logic [SIZE-1:0] step_rem_s;
  logic            step_q_bit_s;

  div_step #(.SIZE(SIZE)) u_div_step (
    .rem_i          (rem_q),
    .dividend_bit_i (dividend_q[SIZE-1]),
    .divisor_i      (divisor_q),
    .rem_o          (step_rem_s),
    .q_bit_o        (step_q_bit_s)
  );

  // Next-state and datapath update; the dividend register doubles as the
  // quotient accumulator, filling from the LSB as dividend bits shift out.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          dividend_d = bus.Data_A;
          divisor_d  = bus.Data_B;
          rem_d      = '0;
          count_d    = '0;
          dbz_d      = (bus.Data_B == '0);
`ifdef DIV_BY_ZERO_SHORTCUT_EN
          if (bus.Data_B == '0) begin
            quotient_d  = '1;
            remainder_d = bus.Data_A;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = CALC;
          end
`else
          busy_d  = 1'b1;
          state_d = CALC;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        rem_d      = step_rem_s;
        dividend_d = {dividend_q[SIZE-2:0], step_q_bit_s};
        count_d    = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          quotient_d  = {dividend_q[SIZE-2:0], step_q_bit_s};
          remainder_d = step_rem_s;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = CALC;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs share one synchronous reset; a Start coinciding
  // with Reset is dropped.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.Quotient    = quotient_q;
  assign bus.Remainder   = remainder_q;
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Div_By_Zero = dbz_q;

endmodule
